// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider and its receive-side meter.
//   CLK_DIV_WIDTH : default counter / ratio width used by both blocks
//   meter_state_e : meter FSM states (ACQUIRE -> TRACK -> LOCKED)
package clk_div_pkg;

    localparam int CLK_DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } meter_state_e;

endpackage

// File: rtl/clk_div_meter_if.sv
// Bundle between a stimulus/consumer (master) and the clock-divider meter (slave).
//   en, div_in      : master -> meter, enable and divided clock under measurement
//   n_out, n_valid  : meter -> master, measured half-period and its update strobe
//   locked, timeout : meter -> master, ratio-stable flag and no-edge pulse
interface clk_div_meter_if #(
    parameter int WIDTH = clk_div_pkg::CLK_DIV_WIDTH
);
    logic             en;
    logic             div_in;
    logic [WIDTH-1:0] n_out;
    logic             n_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output en, div_in,
        input  n_out, n_valid, locked, timeout
    );

    modport slave (
        input  en, div_in,
        output n_out, n_valid, locked, timeout
    );
endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes the divided clock into clk and flags either-polarity transitions.
//   clk, rst : clock and synchronous active-high reset (clears the whole chain to 0)
//   din      : asynchronous (or already synchronous when SYNC_STAGES=0) level input
//   edge_o   : high for one cycle after each change of the synchronized level
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_o
);
    logic s;
    logic s_q, s_d;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign s = din;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb begin
            sync_d    = sync_q;
            sync_d[0] = din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        end

        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= sync_d;
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    assign s_d = s;

    always_ff @(posedge clk) begin
        if (rst) s_q <= 1'b0;
        else     s_q <= s_d;
    end

    // The divider toggles once per half-period, so both polarities are measurement points.
    assign edge_o = s ^ s_q;
endmodule

// File: rtl/clk_div_meter.sv
// Recovers the divide factor n (half-period in clk cycles) of a divided clock.
//   clk, rst : source clock and synchronous active-high reset
//   bus      : slave side of clk_div_meter_if (en, div_in in; n_out, n_valid,
//              locked, timeout out)
// The counter value at an edge is the length of the interval that just ended.
module clk_div_meter
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = CLK_DIV_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_meter_if.slave bus
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_COUNT);

    meter_state_e     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_out_q, n_out_d;
    logic [MW-1:0]    match_q, match_d;
    logic             n_valid_q, n_valid_d;
    logic             timeout_q, timeout_d;
    logic             edge_s;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (bus.div_in),
        .edge_o (edge_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_out_d   = n_out_q;
        match_d   = match_q;
        n_valid_d = 1'b0;
        timeout_d = 1'b0;

        if (!bus.en) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
            match_d = '0;
        end else if (edge_s) begin
            // An edge on the saturation cycle still counts as a (saturated) measurement.
            cnt_d = WIDTH'(1);
            unique case (state_q)
                ACQUIRE: state_d = TRACK;  // first edge only opens an interval
                TRACK: begin
                    n_out_d   = cnt_q;
                    n_valid_d = 1'b1;
                    if (cnt_q == n_out_q)
                        match_d = (match_q == LOCK_M) ? match_q : match_q + MW'(1);
                    else
                        match_d = MW'(1);
                    if (match_d == LOCK_M) state_d = LOCKED;
                end
                LOCKED: begin
                    n_out_d   = cnt_q;
                    n_valid_d = 1'b1;
                    if (cnt_q != n_out_q) begin
                        state_d = TRACK;
                        match_d = MW'(1);
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end else begin
            if (cnt_q != '1) cnt_d = cnt_q + WIDTH'(1);
            // Idle div_in is fine while acquiring; only a lost clock times out.
            if (state_q != ACQUIRE && cnt_q == '1) begin
                timeout_d = 1'b1;
                state_d   = ACQUIRE;
                match_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACQUIRE;
            cnt_q     <= '0;
            n_out_q   <= '0;
            match_q   <= '0;
            n_valid_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_out_q   <= n_out_d;
            match_q   <= match_d;
            n_valid_q <= n_valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.n_out   = n_out_q;
    assign bus.n_valid = n_valid_q;
    assign bus.timeout = timeout_q;
    assign bus.locked  = (state_q == LOCKED);
endmodule

// File: tb/tb_clk_div_meter.sv
// Drives two meters (SYNC_STAGES=2 and 0, WIDTH=8) from one divided-clock source and
// checks them against an interval-based reference model through cycle-stamped queues.
module tb_clk_div_meter;
    localparam int MAXC = 255;
    localparam int LC   = 4;

    typedef struct {
        int cyc;
        int n;
        bit lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic div_in = 1'b0;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state per meter (index 0: 2 sync stages, index 1: none)
    bit hist[2][4];
    bit act[2];
    int age[2];
    int run[2];
    int mnout[2];
    bit mlk[2];
    bit mto[2];

    clk_div_meter_if #(.WIDTH(8)) bus0 ();
    clk_div_meter_if #(.WIDTH(8)) bus1 ();

    assign bus0.en = en;
    assign bus0.div_in = div_in;
    assign bus1.en = en;
    assign bus1.div_in = div_in;

    clk_div_meter #(.WIDTH(8), .SYNC_STAGES(2), .LOCK_COUNT(LC)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    clk_div_meter #(.WIDTH(8), .SYNC_STAGES(0), .LOCK_COUNT(LC)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    // Model: the meter sees div_in delayed by S cycles; a measurement is the number
    // of cycles between consecutive seen transitions, capped at MAXC.
    task automatic model_step(input int d, input int s, input bit r, input bit e, input bit din);
        bit tr;
        int meas;
        exp_t x;
        for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = din;
        if (r) for (int i = 0; i < 4; i++) hist[d][i] = 1'b0;
        tr = hist[d][s] ^ hist[d][s+1];
        mto[d] = 1'b0;
        if (r) begin
            act[d] = 0; age[d] = 0; run[d] = 0; mlk[d] = 0; mnout[d] = 0;
        end else if (!e) begin
            act[d] = 0; age[d] = 0; run[d] = 0; mlk[d] = 0;
        end else if (tr) begin
            if (!act[d]) begin
                act[d] = 1;
            end else begin
                meas = age[d];
                if (meas == mnout[d]) run[d] = run[d] + 1;
                else run[d] = 1;
                if (mlk[d] && meas != mnout[d]) mlk[d] = 0;
                else mlk[d] = (run[d] >= LC);
                mnout[d] = meas;
                x.cyc = cyc; x.n = meas; x.lk = mlk[d];
                if (d == 0) q0.push_back(x);
                else q1.push_back(x);
            end
            age[d] = 1;
        end else begin
            if (act[d] && age[d] == MAXC) begin
                mto[d] = 1; act[d] = 0; run[d] = 0; mlk[d] = 0;
            end
            if (age[d] < MAXC) age[d] = age[d] + 1;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step(0, 2, rst, en, div_in);
        model_step(1, 0, rst, en, div_in);
        mon_on = 1'b1;
    end

    task automatic check(input int d, input bit nv, input logic [7:0] no, input bit lk, input bit to);
        exp_t e;
        bit have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        if (nv) begin
            tests++;
            if (!have) begin
                failed++;
                $display("FAIL dut%0d unexpected_n_valid cyc=%0d got n_out=%0d", d, cyc, no);
            end else begin
                if (d == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                if (e.cyc != cyc || e.n != int'(no) || e.lk != lk) begin
                    failed++;
                    $display("FAIL dut%0d measurement got cyc=%0d n=%0d lk=%0d want cyc=%0d n=%0d lk=%0d",
                             d, cyc, no, lk, e.cyc, e.n, e.lk);
                end
            end
        end else if (have && e.cyc <= cyc) begin
            tests++;
            failed++;
            $display("FAIL dut%0d missing_n_valid got none want cyc=%0d n=%0d", d, e.cyc, e.n);
            if (d == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
        tests++;
        if (to != mto[d]) begin
            failed++;
            $display("FAIL dut%0d timeout cyc=%0d got %0d want %0d", d, cyc, to, mto[d]);
        end
        tests++;
        if (lk != mlk[d] || int'(no) != mnout[d]) begin
            failed++;
            $display("FAIL dut%0d state cyc=%0d got lk=%0d n=%0d want lk=%0d n=%0d",
                     d, cyc, lk, no, mlk[d], mnout[d]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check(0, bus0.n_valid, bus0.n_out, bus0.locked, bus0.timeout);
            check(1, bus1.n_valid, bus1.n_out, bus1.locked, bus1.timeout);
        end
    end

    // k half-periods of n cycles each
    task automatic halfp(input int n, input int k);
        repeat (k) begin
            div_in = ~div_in;
            repeat (n) @(negedge clk);
        end
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        en = 1'b1;
        idle(4);
        halfp(5, 12);                 // lock at n=5
        halfp(1, 10);                 // fastest ratio
        halfp(5, 8);
        halfp(7, 8);                  // ratio change while locked
        halfp(3, 8);
        idle(300);                    // stop: timeout with n_out held
        halfp(3, 6);                  // restart through ACQUIRE
        halfp(255, 3);                // interval exactly at saturation
        halfp(256, 3);                // one beyond saturation -> timeout then reacquire
        halfp(6, 5);
        idle(2);
        rst = 1'b1; idle(1); rst = 1'b0;   // reset mid half-period
        halfp(6, 8);
        idle(2);
        en = 1'b0; idle(2); en = 1'b1;     // enable drop keeps n_out
        halfp(4, 8);
        for (int it = 0; it < 24; it++) begin
            int n, k, a;
            n = $urandom_range(1, 12);
            k = $urandom_range(2, 10);
            a = $urandom_range(0, 9);
            halfp(n, k);
            if (a == 0) begin
                rst = 1'b1; idle(1); rst = 1'b0;
            end else if (a == 1) begin
                en = 1'b0; idle($urandom_range(1, 4)); en = 1'b1;
            end else if (a == 2) begin
                idle(260);
            end
        end
        idle(10);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failed++;
            $display("FAIL drain got pending %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
